cycle_run_ctrl: RTL and testbench

Synthesizable run controller that replaces hand-toggled clock stimulus for the single-cycle processor `arch`. It sits between the free-running `clk` and the core, and drives a core clock enable and a core reset. It runs the core for a programmable number of cycles, single-steps it, and halts on PC breakpoints or an external request. It reports the cycle count and the halt cause to the bench or debug logic.

---
 rtl/run_ctrl_pkg.sv | 18 +
 rtl/bp_match.sv | 22 ++
 rtl/cycle_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cycle_run_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the cycle run controller.
// Holds the FSM state encoding and the halt cause codes.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE_RST,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_e;

    localparam logic [1:0] CAUSE_LIMIT = 2'd0;
    localparam logic [1:0] CAUSE_BREAK = 2'd1;
    localparam logic [1:0] CAUSE_EXT   = 2'd2;
    localparam logic [1:0] CAUSE_STEP  = 2'd3;

endpackage

// File: rtl/bp_match.sv
// NUM_BP-way PC breakpoint comparator.
// Purely combinational; bp_hit is high when any enabled entry matches pc.
module bp_match #(
    parameter int NUM_BP = 2,
    parameter int PC_W   = 32
) (
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    output logic                   bp_hit
);

    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
                bp_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cycle_run_ctrl.sv
// Run controller for a single-cycle core: reset, run, step and halt.
// Drives a combinational core clock enable and a registered core reset.
module cycle_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_W        = 16,
    parameter int PC_W           = 32,
    parameter int NUM_BP         = 2,
    parameter int DEFAULT_CYCLES = 17,
    parameter int RST_CYCLES     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   resume,
    input  logic                   step,
    input  logic                   halt_req,
    input  logic [CYCLE_W-1:0]     run_len,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0]        pc,
    output logic                   core_en,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   halted,
    output logic                   done,
    output logic [1:0]             done_cause,
    output logic [CYCLE_W-1:0]     cycle_cnt
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    state_e             state_q, state_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CYCLE_W-1:0] len_q, len_d;
    logic [CYCLE_W-1:0] cnt_q, cnt_d;
    logic               skip_bp_q, skip_bp_d;
    logic [1:0]         cause_q, cause_d;
    logic               core_rst_q, core_rst_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               done_q, done_d;

    logic               bp_hit;
    logic               en_c;
    logic [CYCLE_W-1:0] len_eff;
    logic [CYCLE_W-1:0] cnt_inc;

    bp_match #(
        .NUM_BP (NUM_BP),
        .PC_W   (PC_W)
    ) u_bp_match (
        .pc      (pc),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .bp_hit  (bp_hit)
    );

    assign len_eff = (run_len == '0) ? CYCLE_W'(DEFAULT_CYCLES) : run_len;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CYCLE_W'(1);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        skip_bp_d = skip_bp_q;
        cause_d   = cause_q;
        en_c      = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    len_d     = len_eff;
                    cnt_d     = '0;
                    rst_cnt_d = '0;
                    skip_bp_d = 1'b0;
                    state_d   = S_CORE_RST;
                end else if (state_q == S_HALTED && resume) begin
                    len_d     = len_eff;
                    skip_bp_d = 1'b1;
                    state_d   = S_RUN;
                end else if (state_q == S_HALTED && step) begin
                    state_d   = S_STEP;
                end
            end
            S_CORE_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_RUN: begin
                skip_bp_d = 1'b0;
                // >= covers a resume whose new limit is already behind us
                if (halt_req) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_EXT;
                end else if (cnt_q >= len_q) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_LIMIT;
                end else if (bp_hit && !skip_bp_q) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_BREAK;
                end else begin
                    en_c  = 1'b1;
                    cnt_d = cnt_inc;
                end
            end
            S_STEP: begin
                state_d = S_HALTED;
                if (halt_req) begin
                    cause_d = CAUSE_EXT;
                end else begin
                    en_c    = 1'b1;
                    cnt_d   = cnt_inc;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_d = (state_d == S_CORE_RST);
        busy_d     = (state_d == S_CORE_RST) || (state_d == S_RUN)
                  || (state_d == S_STEP);
        halted_d   = (state_d == S_HALTED);
        done_d     = (state_d == S_HALTED) && (state_q != S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            skip_bp_q  <= 1'b0;
            cause_q    <= CAUSE_LIMIT;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            skip_bp_q  <= skip_bp_d;
            cause_q    <= cause_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            done_q     <= done_d;
        end
    end

    assign core_en    = en_c && !rst;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign done       = done_q;
    assign done_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cycle_run_ctrl.sv
// Scoreboard bench for cycle_run_ctrl: stimulus pushes expected halts,
// a monitor pops and compares on every done pulse.
module tb_cycle_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        resume;
    logic        step;
    logic        halt_req;
    logic [15:0] run_len;
    logic [1:0]  bp_en;
    logic [63:0] bp_addr;
    logic [31:0] pc;
    logic        core_en;
    logic        core_rst;
    logic        busy;
    logic        halted;
    logic        done;
    logic [1:0]  done_cause;
    logic [15:0] cycle_cnt;

    typedef struct {
        int cause;
        int cnt;
        int en;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   en_count = 0;
    logic en_s = 1'b0;

    cycle_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .resume     (resume),
        .step       (step),
        .halt_req   (halt_req),
        .run_len    (run_len),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .core_en    (core_en),
        .core_rst   (core_rst),
        .busy       (busy),
        .halted     (halted),
        .done       (done),
        .done_cause (done_cause),
        .cycle_cnt  (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int cause, input int cnt, input int en);
        exp_t e;
        e.cause = cause;
        e.cnt   = cnt;
        e.en    = en;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int max, output int nrst);
        nrst = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (core_rst) nrst++;
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    // Core model: pc advances by 4 for every enabled cycle
    initial begin
        forever begin
            @(negedge clk);
            en_s = core_en;
            @(posedge clk);
            #1;
            if (core_rst) pc = 32'h0;
            else if (en_s) pc = pc + 32'd4;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                en_count = 0;
            end else begin
                if (core_en) en_count++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cause", int'(done_cause), e.cause);
                        chk("cycle_cnt", int'(cycle_cnt), e.cnt);
                        chk("en_cycles", en_count, e.en);
                    end
                    en_count = 0;
                end
            end
        end
    end

    initial begin
        int nrst;
        rst = 1'b1;
        start = 1'b0;
        resume = 1'b0;
        step = 1'b0;
        halt_req = 1'b0;
        run_len = 16'd0;
        bp_en = 2'b00;
        bp_addr = 64'h0;
        pc = 32'h0;

        tick();
        tick();
        @(negedge clk);
        chk("en_in_rst", int'(core_en), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_core_en", int'(core_en), 0);
        chk("rst_core_rst", int'(core_rst), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cause", int'(done_cause), 0);
        chk("rst_cnt", int'(cycle_cnt), 0);

        // Default run length
        push(0, 17, 17);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, nrst);
        chk("default_rst_cycles", nrst, 2);
        chk("default_halted", int'(halted), 1);

        // Breakpoint at 0x0C, then resume to the limit
        bp_en = 2'b01;
        bp_addr[31:0] = 32'h0000_000C;
        run_len = 16'd100;
        push(1, 3, 3);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, nrst);
        chk("bp_pc", int'(pc), 12);
        chk("bp_core_en", int'(core_en), 0);
        push(0, 100, 97);
        tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        wait_done(300, nrst);

        // Three single steps; the last holds step into STEP
        push(3, 101, 1);
        push(3, 102, 1);
        push(3, 103, 1);
        for (int s = 0; s < 2; s++) begin
            tick();
            step = 1'b1;
            tick();
            step = 1'b0;
            wait_done(20, nrst);
        end
        tick();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        wait_done(20, nrst);

        // Resume with a limit already passed halts at once
        push(0, 103, 0);
        run_len = 16'd5;
        tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        wait_done(20, nrst);

        // halt_req coincident with a breakpoint at cycle 5
        bp_addr[31:0] = 32'h0000_0014;
        run_len = 16'd50;
        push(2, 5, 5);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && cycle_cnt != 16'd5; i++) tick();
        halt_req = 1'b1;
        @(negedge clk);
        chk("hreq_core_en", int'(core_en), 0);
        wait_done(20, nrst);
        halt_req = 1'b0;

        // Reset in the middle of a run
        bp_en = 2'b00;
        run_len = 16'd0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && cycle_cnt != 16'd7; i++) tick();
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_core_en", int'(core_en), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy_after", int'(busy), 0);
        chk("mid_halted_after", int'(halted), 0);
        chk("mid_cnt_after", int'(cycle_cnt), 0);
        chk("mid_core_rst_after", int'(core_rst), 0);
        push(0, 17, 17);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, nrst);
        chk("restart_rst_cycles", nrst, 2);

        // start wins over step in HALTED
        push(0, 17, 17);
        tick();
        start = 1'b1;
        step = 1'b1;
        tick();
        start = 1'b0;
        step = 1'b0;
        wait_done(100, nrst);
        chk("startstep_rst_cycles", nrst, 2);

        // halt_req during STEP suppresses the enable
        push(2, 17, 0);
        halt_req = 1'b1;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(20, nrst);
        halt_req = 1'b0;

        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
